// File: rtl/gcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gcd_pkg
// Description : Shared types and constants for the GCD operand feeder.
//               Holds the sequencer state encoding, the status-word bit
//               layout and the default FIFO depth.
// Revision    : 1.0 - initial release
// ============================================================================
package gcd_pkg;

  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  // Status word layout (all other bits read as zero)
  localparam int c_stat_opcnt_lsb  = 0;
  localparam int c_stat_rescnt_lsb = 5;
  localparam int c_stat_cnt_w      = 5;
  localparam int c_stat_busy_bit   = 10;
  localparam int c_stat_ovf_bit    = 11;
  localparam int c_stat_udf_bit    = 12;

endpackage
`default_nettype wire

// File: rtl/gcd_operand_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : gcd_operand_feeder_if
// Description : Bus bundle for the GCD operand feeder.
//   avs_s0_*  : operand-A holding register write
//   avs_s1_*  : operand-B write, pushes {A_hold, B}
//   avs_s2_*  : result FIFO pop, registered readdata
//   avs_s3_*  : status read, registered readdata
//   gcd_*     : operands/start to and done/result from the GCD engine
//   slave modport = feeder view, master modport = host/engine view.
// Revision    : 1.0 - initial release
// ============================================================================
interface gcd_operand_feeder_if;
  logic        avs_s0_write;
  logic [31:0] avs_s0_writedata;
  logic        avs_s1_write;
  logic [31:0] avs_s1_writedata;
  logic        avs_s2_read;
  logic [31:0] avs_s2_readdata;
  logic        avs_s3_read;
  logic [31:0] avs_s3_readdata;
  logic [31:0] gcd_a;
  logic [31:0] gcd_b;
  logic        gcd_start;
  logic        gcd_done;
  logic [31:0] gcd_result;

  modport slave (
    input  avs_s0_write, avs_s0_writedata, avs_s1_write, avs_s1_writedata,
    input  avs_s2_read, avs_s3_read, gcd_done, gcd_result,
    output avs_s2_readdata, avs_s3_readdata, gcd_a, gcd_b, gcd_start
  );

  modport master (
    output avs_s0_write, avs_s0_writedata, avs_s1_write, avs_s1_writedata,
    output avs_s2_read, avs_s3_read, gcd_done, gcd_result,
    input  avs_s2_readdata, avs_s3_readdata, gcd_a, gcd_b, gcd_start
  );
endinterface
`default_nettype wire

// File: rtl/gcd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gcd_fifo
// Description : Synchronous FIFO with registered storage and first-word
//               fall-through head. A push while full is accepted when a pop
//               happens in the same cycle.
//   clk, rst        : clock, synchronous active-high reset
//   i_push, i_wdata : write request and data
//   i_pop           : read request (ignored when empty)
//   o_rdata         : current head entry
//   o_full, o_empty, o_count : occupancy (count spans 0..DEPTH)
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pointers are exactly log2(DEPTH) wide, so they wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/gcd_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : gcd_operand_feeder
// Description : Collects {A, B} operand pairs from a host, issues them one at
//               a time to a GCD engine and queues the results for readback.
//   csi_clk   : clock, rising edge
//   rsi_reset : synchronous active-high reset
//   bus       : host ports s0 (A), s1 (B/push), s2 (result pop),
//               s3 (status) and the engine operand/start/done/result ports
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_operand_feeder
  import gcd_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                  csi_clk,
  input  logic                  rsi_reset,
  gcd_operand_feeder_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_a_hold;
  logic [31:0] r_result;
  logic [31:0] r_gcd_a;
  logic [31:0] r_gcd_b;
  logic        r_gcd_start;
  logic [31:0] r_s2_rdata;
  logic [31:0] r_s3_rdata;
  logic        r_ovf;
  logic        r_udf;

  logic          w_launch;
  logic          w_op_pop;
  logic          w_capture;
  logic          w_res_push;
  logic [63:0]   w_op_head;
  logic          w_op_full;
  logic          w_op_empty;
  logic [CW-1:0] w_op_count;
  logic [31:0]   w_res_head;
  logic          w_res_full;
  logic          w_res_empty;
  logic [CW-1:0] w_res_count;
  logic          w_res_pop;
  logic          w_ovf_set;
  logic          w_udf_set;
  logic [31:0]   w_status;

  // The old A_hold is pushed even when s0 is written in the same cycle.
  gcd_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_op_fifo (
    .clk     (csi_clk),
    .rst     (rsi_reset),
    .i_push  (bus.avs_s1_write),
    .i_wdata ({r_a_hold, bus.avs_s1_writedata}),
    .i_pop   (w_op_pop),
    .o_rdata (w_op_head),
    .o_full  (w_op_full),
    .o_empty (w_op_empty),
    .o_count (w_op_count)
  );

  gcd_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_res_fifo (
    .clk     (csi_clk),
    .rst     (rsi_reset),
    .i_push  (w_res_push),
    .i_wdata (r_result),
    .i_pop   (w_res_pop),
    .o_rdata (w_res_head),
    .o_full  (w_res_full),
    .o_empty (w_res_empty),
    .o_count (w_res_count)
  );

  assign w_res_pop = bus.avs_s2_read && !w_res_empty;
  assign w_udf_set = bus.avs_s2_read && w_res_empty;
  assign w_ovf_set = bus.avs_s1_write && w_op_full && !w_op_pop;

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) r_state <= ST_IDLE;
    else           r_state <= w_state_next;
  end

  // Only one pair is ever in flight, so in IDLE no result slot is reserved
  // and "result FIFO not full" is enough to guarantee the STORE push.
  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_op_pop     = 1'b0;
    w_capture    = 1'b0;
    w_res_push   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_op_empty && !w_res_full) begin
          w_launch     = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_op_pop     = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.gcd_done) begin
          w_capture    = 1'b1;
          w_state_next = ST_STORE;
        end
      end
      ST_STORE: begin
        w_res_push   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_status = '0;
    w_status[c_stat_opcnt_lsb +: c_stat_cnt_w]  = 5'(w_op_count);
    w_status[c_stat_rescnt_lsb +: c_stat_cnt_w] = 5'(w_res_count);
    w_status[c_stat_busy_bit] = (r_state != ST_IDLE);
    w_status[c_stat_ovf_bit]  = r_ovf;
    w_status[c_stat_udf_bit]  = r_udf;
  end

  // Operands are latched from the FIFO head on launch so they are valid
  // together with the start pulse, and stay put until the next launch.
  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      r_a_hold    <= '0;
      r_result    <= '0;
      r_gcd_a     <= '0;
      r_gcd_b     <= '0;
      r_gcd_start <= 1'b0;
      r_s2_rdata  <= '0;
      r_s3_rdata  <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
    end else begin
      r_gcd_start <= w_launch;
      if (w_launch) begin
        r_gcd_a <= w_op_head[63:32];
        r_gcd_b <= w_op_head[31:0];
      end
      if (w_capture)            r_result   <= bus.gcd_result;
      if (bus.avs_s0_write)     r_a_hold   <= bus.avs_s0_writedata;
      if (bus.avs_s2_read)      r_s2_rdata <= w_res_empty ? 32'd0 : w_res_head;
      if (bus.avs_s3_read)      r_s3_rdata <= w_status;
      // Status read samples the flags first; a new event in that cycle wins.
      r_ovf <= w_ovf_set | (r_ovf & ~bus.avs_s3_read);
      r_udf <= w_udf_set | (r_udf & ~bus.avs_s3_read);
    end
  end

  assign bus.gcd_a           = r_gcd_a;
  assign bus.gcd_b           = r_gcd_b;
  assign bus.gcd_start       = r_gcd_start;
  assign bus.avs_s2_readdata = r_s2_rdata;
  assign bus.avs_s3_readdata = r_s3_rdata;

endmodule
`default_nettype wire

// File: tb/tb_gcd_operand_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_operand_feeder
// Description : Self-checking bench for gcd_operand_feeder. A queue-level
//               model tracks accepted pairs, results and sticky flags; a
//               stub engine answers each start with the true GCD.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gcd_operand_feeder;

  localparam int DEPTH = 4;

  logic csi_clk = 1'b0;
  logic rsi_reset;
  int   n_checks = 0;
  int   n_err    = 0;

  always #5 csi_clk = ~csi_clk;

  gcd_operand_feeder_if bus();

  gcd_operand_feeder #(.DEPTH(DEPTH)) u_dut (
    .csi_clk   (csi_clk),
    .rsi_reset (rsi_reset),
    .bus       (bus)
  );

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (updated on rising edge) -------------
  logic [63:0] m_op[$];
  logic [31:0] m_res[$];
  logic [31:0] m_a;
  bit          m_ovf, m_udf, m_wait, m_store;
  bit          m_rst = 1'b1;
  logic [63:0] m_fly;
  logic [31:0] m_store_val;
  bit          exp2_v, exp3_v;
  logic [31:0] exp2, exp3;

  always @(posedge csi_clk) begin
    bit pop, ovf_set, udf_set, busy;
    int occ;
    m_rst  = rsi_reset;
    exp2_v = 1'b0;
    exp3_v = 1'b0;
    if (rsi_reset) begin
      m_op.delete();
      m_res.delete();
      m_a = '0; m_ovf = 0; m_udf = 0; m_wait = 0; m_store = 0;
      exp2_v = 1'b1; exp2 = '0;
      exp3_v = 1'b1; exp3 = '0;
    end else begin
      pop = bus.gcd_start;
      ovf_set = 0;
      udf_set = 0;
      busy = pop || m_wait || m_store;
      if (bus.avs_s3_read) begin
        exp3 = '0;
        exp3[4:0] = 5'(m_op.size());
        exp3[9:5] = 5'(m_res.size());
        exp3[10]  = busy;
        exp3[11]  = m_ovf;
        exp3[12]  = m_udf;
        exp3_v = 1'b1;
      end
      if (bus.avs_s2_read) begin
        exp2_v = 1'b1;
        if (m_res.size() > 0) exp2 = m_res.pop_front();
        else begin
          exp2 = '0;
          udf_set = 1;
        end
      end
      if (m_store) begin
        m_res.push_back(m_store_val);
        m_store = 0;
      end
      if (m_wait && bus.gcd_done) begin
        m_store = 1;
        m_wait  = 0;
        m_store_val = gcd_ref(m_fly[63:32], m_fly[31:0]);
      end
      occ = m_op.size();
      if (pop && occ > 0) begin
        m_fly  = m_op.pop_front();
        m_wait = 1;
      end
      if (bus.avs_s1_write) begin
        if (occ < DEPTH || pop) m_op.push_back({m_a, bus.avs_s1_writedata});
        else ovf_set = 1;
      end
      if (bus.avs_s0_write) m_a = bus.avs_s0_writedata;
      m_ovf = ovf_set | (m_ovf & !bus.avs_s3_read);
      m_udf = udf_set | (m_udf & !bus.avs_s3_read);
    end
  end

  // ---------------- stub GCD engine (drives on falling edge) -------------
  bit          eng_stall = 1'b0;
  bit          eng_busy  = 1'b0;
  bit          inj_done  = 1'b0;
  int          eng_lat   = 10;
  int          eng_cnt;
  logic [31:0] eng_res;
  logic [31:0] inj_val;

  always @(negedge csi_clk) begin
    bus.gcd_done = 1'b0;
    if (m_rst) begin
      eng_busy = 0;
      bus.gcd_result = '0;
    end else if (bus.gcd_start && !eng_busy) begin
      eng_busy = 1;
      eng_cnt  = eng_lat;
      eng_res  = gcd_ref(bus.gcd_a, bus.gcd_b);
    end else if (eng_busy && !eng_stall) begin
      if (eng_cnt <= 1) begin
        bus.gcd_done   = 1'b1;
        bus.gcd_result = eng_res;
        eng_busy = 0;
      end else eng_cnt--;
    end
    if (inj_done) begin
      bus.gcd_done   = 1'b1;
      bus.gcd_result = inj_val;
    end
  end

  // ---------------- compare process (falling edge) -----------------------
  int          since_start = 100;
  int          n_starts    = 0;

  always @(negedge csi_clk) begin
    if (exp2_v) chk("s2_readdata", bus.avs_s2_readdata, exp2);
    if (exp3_v) chk("s3_status", bus.avs_s3_readdata, exp3);
    if (m_rst) since_start = 100;
    else if (since_start < 100) since_start++;
    if (bus.gcd_start) begin
      n_starts++;
      chk("start_spacing", 32'(since_start >= 4), 32'd1);
      chk("start_has_pair", 32'(m_op.size() > 0), 32'd1);
      chk("start_res_room", 32'(m_res.size() < DEPTH && !m_wait && !m_store), 32'd1);
      if (m_op.size() > 0) begin
        chk("gcd_a", bus.gcd_a, m_op[0][63:32]);
        chk("gcd_b", bus.gcd_b, m_op[0][31:0]);
      end
      since_start = 0;
    end
  end

  // ---------------- stimulus helpers -------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge csi_clk);
  endtask

  task automatic wr_a(input logic [31:0] v);
    bus.avs_s0_write = 1'b1; bus.avs_s0_writedata = v;
    tick();
    bus.avs_s0_write = 1'b0;
  endtask

  task automatic wr_b(input logic [31:0] v);
    bus.avs_s1_write = 1'b1; bus.avs_s1_writedata = v;
    tick();
    bus.avs_s1_write = 1'b0;
  endtask

  task automatic wr_pair(input logic [31:0] a, input logic [31:0] b);
    wr_a(a);
    wr_b(b);
  endtask

  task automatic rd_res(output logic [31:0] v);
    bus.avs_s2_read = 1'b1;
    tick();
    bus.avs_s2_read = 1'b0;
    v = bus.avs_s2_readdata;
  endtask

  task automatic rd_stat(output logic [31:0] v);
    bus.avs_s3_read = 1'b1;
    tick();
    bus.avs_s3_read = 1'b0;
    v = bus.avs_s3_readdata;
  endtask

  task automatic wait_start(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick();
      if (bus.gcd_start) ok = 1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, v;
    bit ok;
    int ns;
    rsi_reset = 1'b1;
    bus.avs_s0_write = 0; bus.avs_s0_writedata = '0;
    bus.avs_s1_write = 0; bus.avs_s1_writedata = '0;
    bus.avs_s2_read  = 0; bus.avs_s3_read = 0;
    tick(3);
    chk("rst_start", 32'(bus.gcd_start), 0);
    chk("rst_gcd_a", bus.gcd_a, 0);
    chk("rst_gcd_b", bus.gcd_b, 0);
    chk("rst_s2", bus.avs_s2_readdata, 0);
    chk("rst_s3", bus.avs_s3_readdata, 0);
    rsi_reset = 1'b0;
    rd_stat(s);
    chk("rst_status", s, 0);

    // Single pair 48,18 -> 6
    eng_lat = 10;
    wr_pair(48, 18);
    wait_start(10, ok);
    chk("t1_start_seen", 32'(ok), 1);
    chk("t1_gcd_a", bus.gcd_a, 48);
    chk("t1_gcd_b", bus.gcd_b, 18);
    tick(20);
    rd_stat(s);
    chk("t1_rescnt_1", 32'(s[9:5]), 1);
    rd_res(v);
    chk("t1_result", v, 6);
    rd_stat(s);
    chk("t1_rescnt_0", 32'(s[9:5]), 0);
    chk("t1_one_start", n_starts, 1);

    // Underflow
    rd_res(v);
    chk("t2_empty_read", v, 0);
    rd_stat(s);
    chk("t2_udf_set", 32'(s[12]), 1);
    rd_stat(s);
    chk("t2_udf_clr", 32'(s[12]), 0);

    // Overflow with engine stalled, then result FIFO full back-pressure
    eng_stall = 1;
    eng_lat = 3;
    wr_pair(36, 24);
    wait_start(10, ok);
    chk("t3_prime_start", 32'(ok), 1);
    wr_pair(30, 12);
    wr_pair(21, 14);
    wr_pair(81, 27);
    wr_pair(64, 48);
    wr_pair(50, 20);
    rd_stat(s);
    chk("t3_opcnt_4", 32'(s[4:0]), 4);
    chk("t3_ovf_set", 32'(s[11]), 1);
    chk("t3_busy", 32'(s[10]), 1);
    rd_stat(s);
    chk("t3_ovf_clr", 32'(s[11]), 0);
    eng_stall = 0;
    tick(80);
    rd_stat(s);
    chk("t4_rescnt_4", 32'(s[9:5]), 4);
    chk("t4_opcnt_1", 32'(s[4:0]), 1);
    chk("t4_idle", 32'(s[10]), 0);
    ns = n_starts;
    tick(10);
    chk("t4_no_start_full", n_starts, ns);
    rd_res(v);
    chk("t4_res0", v, 12);
    wait_start(2, ok);
    chk("t4_issue_after_pop", 32'(ok), 1);
    tick(20);
    rd_res(v); chk("t4_res1", v, 6);
    rd_res(v); chk("t4_res2", v, 7);
    rd_res(v); chk("t4_res3", v, 27);
    rd_res(v); chk("t4_res4", v, 16);
    rd_stat(s);
    chk("t4_drained", 32'(s[9:0]), 0);

    // Reset during WAIT, then a late done
    eng_stall = 1;
    wr_pair(9, 6);
    wait_start(10, ok);
    chk("t5_start", 32'(ok), 1);
    tick(3);
    rsi_reset = 1'b1;
    tick();
    rsi_reset = 1'b0;
    eng_stall = 0;
    ns = n_starts;
    inj_val  = 32'd3;
    inj_done = 1'b1;
    @(posedge csi_clk);
    @(posedge csi_clk);
    inj_done = 1'b0;
    tick(6);
    rd_stat(s);
    chk("t5_status_clear", s, 0);
    chk("t5_no_new_start", n_starts, ns);

    // Back-to-back pairs with overlapping s0/s1 writes
    eng_lat = 2;
    bus.avs_s0_write = 1; bus.avs_s0_writedata = 12;
    tick();
    bus.avs_s0_writedata = 17; bus.avs_s1_write = 1; bus.avs_s1_writedata = 8;
    tick();
    bus.avs_s0_writedata = 100; bus.avs_s1_writedata = 5;
    tick();
    bus.avs_s0_write = 0; bus.avs_s1_writedata = 75;
    tick();
    bus.avs_s1_write = 0;
    tick(40);
    rd_res(v); chk("t6_res_a", v, 4);
    rd_res(v); chk("t6_res_b", v, 1);
    rd_res(v); chk("t6_res_c", v, 25);

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      bus.avs_s0_write     = ($urandom_range(0, 2) == 0);
      bus.avs_s0_writedata = $urandom_range(1, 500);
      bus.avs_s1_write     = ($urandom_range(0, 2) == 0);
      bus.avs_s1_writedata = $urandom_range(1, 500);
      bus.avs_s2_read      = ($urandom_range(0, 3) == 0);
      bus.avs_s3_read      = ($urandom_range(0, 5) == 0);
      if (c % 50 == 0) eng_stall = ($urandom_range(0, 2) == 0);
      eng_lat = $urandom_range(1, 6);
      tick();
    end
    bus.avs_s0_write = 0; bus.avs_s1_write = 0;
    bus.avs_s2_read = 0; bus.avs_s3_read = 0;
    eng_stall = 0;
    repeat (40) begin
      rd_res(v);
      tick(2);
    end
    rd_stat(s);
    chk("t7_drained", 32'(s[10:0]), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gcd_operand_feeder.md
GCD_OPERAND_FEEDER -- requirements
Module: gcd_operand_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: entries per FIFO, power of two, range 2..16.
REQ-002 The block SHALL have port csi_clk, input, 1: single clock; all logic rising-edge.
REQ-003 The block SHALL have port rsi_reset, input, 1: reset, synchronous, active-high.
REQ-004 The block SHALL have port avs_s0_write, input, 1: load operand-A holding register.
REQ-005 The block SHALL have port avs_s0_writedata, input, 32: operand A.
REQ-006 The block SHALL have port avs_s1_write, input, 1: push {held A, B} pair into operand FIFO.
REQ-007 The block SHALL have port avs_s1_writedata, input, 32: operand B.
REQ-008 The block SHALL have port avs_s2_read, input, 1: pop result FIFO.
REQ-009 The block SHALL have port avs_s2_readdata, output, 32: popped GCD result.
REQ-010 The block SHALL have port avs_s3_read, input, 1: status read, no side effect except sticky-flag clear.
REQ-011 The block SHALL have port avs_s3_readdata, output, 32: status word.
REQ-012 The block SHALL have ports gcd_a and gcd_b, output, 32 each: operands to the downstream GCD engine.
REQ-013 The block SHALL have port gcd_start, output, 1: one-cycle start pulse to the engine.
REQ-014 The block SHALL have ports gcd_done, input, 1, and gcd_result, input, 32: engine completion pulse and result, valid together.

Function
REQ-015 avs_s0_write SHALL load the A holding register; the last write wins.
REQ-016 avs_s1_write with operand FIFO not full SHALL push {A_hold, avs_s1_writedata}; when full, the pair is dropped and sticky overflow is set.
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, STORE.
REQ-018 IDLE->ISSUE when operand FIFO is non-empty and result FIFO has a free slot that is not reserved.
REQ-019 ISSUE SHALL pop the pair, drive gcd_a/gcd_b (held stable until STORE), pulse gcd_start for exactly one cycle, then go to WAIT.
REQ-020 WAIT SHALL hold until gcd_done=1, then capture gcd_result and go to STORE; gcd_done in IDLE/ISSUE/STORE is ignored.
REQ-021 STORE SHALL push the captured result into the result FIFO (slot guaranteed by REQ-018), then go to IDLE; minimum issue-to-issue spacing is 4 cycles.
REQ-022 avs_s2_read with result FIFO non-empty SHALL pop it; avs_s2_readdata is registered and valid the cycle after the read; when empty, readdata=0 and sticky underflow is set.
REQ-023 Simultaneous push and pop on the same FIFO SHALL both succeed, with count unchanged. A push while full with a simultaneous pop is accepted.
REQ-024 Pointers SHALL wrap modulo DEPTH; counts span 0..DEPTH.
REQ-025 Status word: [4:0] operand count, [9:5] result count, [10] busy (state != IDLE), [11] overflow, [12] underflow, others 0.
REQ-026 avs_s3_readdata SHALL be registered with 1-cycle latency; a status read SHALL clear overflow/underflow after sampling; a same-cycle set wins over the clear.
REQ-027 A same-cycle avs_s0_write and avs_s1_write SHALL push the old A_hold; the new A takes effect afterwards.

Reset
REQ-028 Reset SHALL force state IDLE, both FIFOs empty, A_hold=0, sticky flags 0, and gcd_start, gcd_a, gcd_b, avs_s2_readdata and avs_s3_readdata all 0.
REQ-029 Reset mid-operation SHALL abandon the in-flight pair; a gcd_done arriving after reset is ignored per REQ-020.

Structure
REQ-030 Package gcd_pkg SHALL hold the FSM state enum, status bit-position constants and default DEPTH.
REQ-031 A sub-module gcd_fifo (parameterised width/depth, registered storage, full/empty/count) SHALL be instantiated twice: 64-bit operand FIFO and 32-bit result FIFO.

Verification
REQ-032 Write A=48, write B=18, stub engine returning 6 after 10 cycles -> exactly one gcd_start pulse with gcd_a=48, gcd_b=18; s2 read returns 6; status result count goes 1->0.
REQ-033 Push 5 pairs with DEPTH=4 while engine stalled -> 4 accepted, overflow bit 11=1; a status read clears it on the next read.
REQ-034 Read s2 with result FIFO empty -> readdata=0 and underflow bit 12=1.
REQ-035 Fill result FIFO to 4, queue one more pair -> no gcd_start until one s2 pop, then issue within 2 cycles.
REQ-036 Assert rsi_reset during WAIT, then pulse gcd_done -> no result pushed, counts 0, busy 0.
REQ-037 Pairs (12,8), (17,5), (100,75) back-to-back -> results 4, 1, 25 popped in order.
